// File: rtl/hack_mem_arbiter.sv
// Single-port data-RAM arbiter sharing the Hack CPU memory port with a DMA master.
// Grants at most one access per cycle; read data returns one cycle after issue.
module hack_mem_arbiter #(
  parameter int DMA_MAX_BURST = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [15:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    DMA_RD
  } state_t;

  localparam logic [3:0] BURST_MAX  = 4'(DMA_MAX_BURST);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [3:0]  burst_cnt;
  logic [15:0] cpu_rdata_q;

  logic cpu_can;
  logic dma_can;
  logic grant_cpu;
  logic grant_dma;

  // While the CPU read is returning, the still-held request must not be reissued.
  assign cpu_can = reset_n && cpu_req && (state != CPU_RD);
  assign dma_can = reset_n && dma_req;

  // A full burst hands the slot back to the CPU even when the DMA is starving.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (cpu_can) begin
      if (dma_can && (starve_cnt == STARVE_MAX) && (burst_cnt != BURST_MAX))
        grant_dma = 1'b1;
      else
        grant_cpu = 1'b1;
    end else if (dma_can) begin
      grant_dma = 1'b1;
    end
  end

  always_comb begin
    mem_en    = grant_cpu | grant_dma;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (grant_dma) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (grant_cpu) begin
      mem_we = cpu_we;
    end
  end

  assign dma_gnt    = grant_dma;
  assign cpu_stall  = cpu_req && !((grant_cpu && cpu_we) || (state == CPU_RD));
  assign cpu_rdata  = (state == CPU_RD) ? mem_rdata : cpu_rdata_q;
  assign dma_rvalid = (state == DMA_RD);
  assign dma_rdata  = (state == DMA_RD) ? mem_rdata : 16'h0000;

  // The state records whose read data arrives next cycle; writes finish in place.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      burst_cnt   <= 4'd0;
      cpu_rdata_q <= 16'h0000;
    end else begin
      if (state == CPU_RD)
        cpu_rdata_q <= mem_rdata;

      if (grant_cpu && !cpu_we)
        state <= CPU_RD;
      else if (grant_dma && !dma_we)
        state <= DMA_RD;
      else
        state <= IDLE;

      if (grant_dma)
        starve_cnt <= 4'd0;
      else if (dma_req && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;

      if (!cpu_req || grant_cpu)
        burst_cnt <= 4'd0;
      else if (grant_dma && (burst_cnt != BURST_MAX))
        burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule
